// File: rtl/mem_arbiter_if.sv
// Bundled core, debug and RAM-port signals of the shared data-RAM arbiter.
// The arbiter takes the slave view; requesters and the RAM model take the master view.
interface mem_arbiter_if #(
   parameter int unsigned ADDR_W = 12
);
   logic              core_req;
   logic [3:0]        core_we;
   logic [31:0]       core_addr;
   logic [31:0]       core_wdata;
   logic              core_hold;
   logic [31:0]       core_rdata;
   logic              core_rvld;

   logic              dbg_req;
   logic              dbg_lock;
   logic [3:0]        dbg_we;
   logic [31:0]       dbg_addr;
   logic [31:0]       dbg_wdata;
   logic              dbg_gnt;
   logic [31:0]       dbg_rdata;
   logic              dbg_rvld;

   logic              mem_en;
   logic [3:0]        mem_we;
   logic [ADDR_W-3:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   modport slave (
      input  core_req, core_we, core_addr, core_wdata,
      output core_hold, core_rdata, core_rvld,
      input  dbg_req, dbg_lock, dbg_we, dbg_addr, dbg_wdata,
      output dbg_gnt, dbg_rdata, dbg_rvld,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output core_req, core_we, core_addr, core_wdata,
      input  core_hold, core_rdata, core_rvld,
      output dbg_req, dbg_lock, dbg_we, dbg_addr, dbg_wdata,
      input  dbg_gnt, dbg_rdata, dbg_rvld,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port data-RAM arbiter between the core MEM stage and a debug/loader port.
// Define MEM_ARB_LOCK_EN to add the debug burst-lock (LOCK state with bounded lock_cnt).
module mem_arbiter #(
   parameter int unsigned ADDR_W   = 12,
   parameter int unsigned LOCK_MAX = 16
) (
   input logic          clk_i,
   input logic          rst_ni,
   mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StCore, StDbg, StLock} state_e;

   state_e state_q, state_d;
   logic   core_gnt, dbg_gnt;
   logic   rd_core_q, rd_core_d;
   logic   rd_dbg_q, rd_dbg_d;

`ifdef MEM_ARB_LOCK_EN
   localparam int unsigned CntW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(LOCK_MAX - 1);

   logic [CntW-1:0] cnt_q, cnt_d;
`endif

   always_comb begin
      // Tie goes to the side not granted last; idle and lock both count as debug-last.
      core_gnt = bus.core_req & (~bus.dbg_req | (state_q != StCore));
      dbg_gnt  = bus.dbg_req & ~core_gnt;
`ifdef MEM_ARB_LOCK_EN
      cnt_d = '0;
      if (state_q == StLock) begin
         if (bus.core_req && (cnt_q == CntMax)) begin
            core_gnt = 1'b1;
            dbg_gnt  = 1'b0;
         end else if (bus.dbg_req && bus.dbg_lock) begin
            core_gnt = 1'b0;
            dbg_gnt  = 1'b1;
            cnt_d    = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
         end
      end
`endif
      state_d = StIdle;
      if (core_gnt) begin
         state_d = StCore;
      end else if (dbg_gnt) begin
         state_d = StDbg;
`ifdef MEM_ARB_LOCK_EN
         if (bus.dbg_lock) begin
            state_d = StLock;
         end
`endif
      end
   end

   assign rd_core_d = core_gnt & (bus.core_we == 4'h0);
   assign rd_dbg_d  = dbg_gnt & (bus.dbg_we == 4'h0);

   always_comb begin
      bus.mem_en    = core_gnt | dbg_gnt;
      bus.mem_we    = '0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (core_gnt) begin
         bus.mem_we    = bus.core_we;
         bus.mem_addr  = bus.core_addr[ADDR_W-1:2];
         bus.mem_wdata = bus.core_wdata;
      end else if (dbg_gnt) begin
         bus.mem_we    = bus.dbg_we;
         bus.mem_addr  = bus.dbg_addr[ADDR_W-1:2];
         bus.mem_wdata = bus.dbg_wdata;
      end
   end

   assign bus.core_hold  = bus.core_req & ~core_gnt;
   assign bus.dbg_gnt    = dbg_gnt;
   assign bus.core_rvld  = rd_core_q;
   assign bus.core_rdata = rd_core_q ? bus.mem_rdata : '0;
   assign bus.dbg_rvld   = rd_dbg_q;
   assign bus.dbg_rdata  = rd_dbg_q ? bus.mem_rdata : '0;

   // Reset also drops any read still in flight.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         rd_core_q <= 1'b0;
         rd_dbg_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_core_q <= rd_core_d;
         rd_dbg_q  <= rd_dbg_d;
      end
   end

   logic unused_bits;
`ifdef MEM_ARB_LOCK_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign unused_bits = ^{bus.core_addr[31:ADDR_W], bus.core_addr[1:0],
                          bus.dbg_addr[31:ADDR_W], bus.dbg_addr[1:0]};
`else
   assign unused_bits = ^{bus.core_addr[31:ADDR_W], bus.core_addr[1:0],
                          bus.dbg_addr[31:ADDR_W], bus.dbg_addr[1:0],
                          bus.dbg_lock, (LOCK_MAX == 0)};
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a grant-level reference model checked every cycle,
// plus literal expectations for the reset, read, write, alternation and lock scenarios.
module tb_mem_arbiter;
   localparam int unsigned AW      = 12;
   localparam int          LockMax = 16;
`ifdef MEM_ARB_LOCK_EN
   localparam bit LockEn = 1'b1;
`else
   localparam bit LockEn = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   // Model: who was granted last (0 none, 1 core, 2 debug), lock status, pending read owner.
   int m_prev = 0;
   bit m_lock = 1'b0;
   int m_cnt  = 0;
   int m_pend = 0;

   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(AW)) bus ();

   mem_arbiter #(.ADDR_W(AW), .LOCK_MAX(LockMax)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endfunction

   always @(negedge clk) begin : cmp
      int          who;
      logic [3:0]  e_we;
      logic [31:0] e_addr;
      logic [31:0] e_wdata;
      if (!rst_n) begin
         m_prev = 0;
         m_lock = 1'b0;
         m_cnt  = 0;
         m_pend = 0;
      end
      who = 0;
      if (LockEn && m_lock && bus.core_req && (m_cnt >= LockMax - 1)) who = 1;
      else if (LockEn && m_lock && bus.dbg_req && bus.dbg_lock) who = 2;
      else if (bus.core_req && bus.dbg_req) who = (m_prev == 1) ? 2 : 1;
      else if (bus.core_req) who = 1;
      else if (bus.dbg_req) who = 2;

      e_we = 4'h0; e_addr = 32'h0; e_wdata = 32'h0;
      if (who == 1) begin
         e_we = bus.core_we; e_addr = 32'(bus.core_addr[AW-1:2]); e_wdata = bus.core_wdata;
      end else if (who == 2) begin
         e_we = bus.dbg_we; e_addr = 32'(bus.dbg_addr[AW-1:2]); e_wdata = bus.dbg_wdata;
      end

      check("core_hold", 32'(bus.core_hold), 32'(bus.core_req && who != 1));
      check("dbg_gnt", 32'(bus.dbg_gnt), 32'(who == 2));
      check("mem_en", 32'(bus.mem_en), 32'(who != 0));
      check("mem_we", 32'(bus.mem_we), 32'(e_we));
      check("mem_addr", 32'(bus.mem_addr), e_addr);
      check("mem_wdata", bus.mem_wdata, e_wdata);
      check("core_rvld", 32'(bus.core_rvld), 32'(m_pend == 1));
      check("core_rdata", bus.core_rdata, (m_pend == 1) ? bus.mem_rdata : 32'h0);
      check("dbg_rvld", 32'(bus.dbg_rvld), 32'(m_pend == 2));
      check("dbg_rdata", bus.dbg_rdata, (m_pend == 2) ? bus.mem_rdata : 32'h0);

      if (rst_n) begin
         m_pend = (who != 0 && e_we == 4'h0) ? who : 0;
         if (LockEn && who == 2 && bus.dbg_lock) begin
            m_cnt  = !m_lock ? 0 : (m_cnt < LockMax - 1) ? m_cnt + 1 : m_cnt;
            m_lock = 1'b1;
         end else begin
            m_lock = 1'b0;
            m_cnt  = 0;
         end
         m_prev = who;
      end
   end

   task automatic clear_inputs();
      bus.core_req = 1'b0; bus.core_we = 4'h0; bus.core_addr = 32'h0; bus.core_wdata = 32'h0;
      bus.dbg_req  = 1'b0; bus.dbg_lock = 1'b0; bus.dbg_we = 4'h0;
      bus.dbg_addr = 32'h0; bus.dbg_wdata = 32'h0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      bus.mem_rdata = {16'hC0DE, cyc[15:0]};
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   initial begin
      clear_inputs();
      bus.mem_rdata = 32'h0;
      #1 rst_n = 1'b0;

      // Contention while held in reset: idle rules give the core priority.
      bus.core_req = 1'b1; bus.dbg_req = 1'b1;
      sample();
      check("rst_core_hold", 32'(bus.core_hold), 32'd0);
      check("rst_dbg_gnt", 32'(bus.dbg_gnt), 32'd0);
      check("rst_mem_en", 32'(bus.mem_en), 32'd1);
      check("rst_core_rvld", 32'(bus.core_rvld), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Continuous contention from reset: C, D, C, D.
      for (int i = 0; i < 4; i++) begin
         sample();
         check("rr_dbg_gnt", 32'(bus.dbg_gnt), 32'(i % 2));
         check("rr_core_hold", 32'(bus.core_hold), 32'(i % 2));
         tick();
      end

      // Core read alone at 0x010.
      clear_inputs();
      bus.core_req = 1'b1; bus.core_addr = 32'h0000_0010;
      sample();
      check("rd_mem_addr", 32'(bus.mem_addr), 32'd4);
      check("rd_core_hold", 32'(bus.core_hold), 32'd0);
      tick();
      clear_inputs();
      bus.mem_rdata = 32'hDEAD_BEEF;
      sample();
      check("rd_core_rvld", 32'(bus.core_rvld), 32'd1);
      check("rd_core_rdata", bus.core_rdata, 32'hDEAD_BEEF);
      tick();

      // Debug full-word write at 0x020.
      bus.dbg_req = 1'b1; bus.dbg_we = 4'hF;
      bus.dbg_addr = 32'h0000_0020; bus.dbg_wdata = 32'h1234_5678;
      sample();
      check("wr_mem_we", 32'(bus.mem_we), 32'h0000_000F);
      check("wr_mem_addr", 32'(bus.mem_addr), 32'd8);
      check("wr_mem_wdata", bus.mem_wdata, 32'h1234_5678);
      tick();
      clear_inputs();
      sample();
      check("wr_dbg_rvld", 32'(bus.dbg_rvld), 32'd0);
      tick();

      // Back-to-back contended accesses, one core byte write mixed in.
      for (int i = 0; i < 6; i++) begin
         bus.core_req = 1'b1; bus.dbg_req = 1'b1;
         bus.core_addr = 32'(i * 16 + 4); bus.dbg_addr = 32'(i * 8 + 'h100);
         bus.core_we = (i == 2) ? 4'h3 : 4'h0; bus.core_wdata = 32'(i * 'h1111);
         sample();
         tick();
      end
      clear_inputs();
      sample();
      tick();

      // Reset lands while a core read is in flight.
      bus.core_req = 1'b1; bus.core_addr = 32'h0000_0040;
      sample();
      tick();
      clear_inputs();
      rst_n = 1'b0;
      #1;
      check("rst_inflight_rvld", 32'(bus.core_rvld), 32'd0);
      bus.core_req = 1'b1; bus.dbg_req = 1'b1; bus.dbg_lock = 1'b1;
      sample();
      tick();
      rst_n = 1'b1;
      sample();
      check("post_rst_dbg_gnt", 32'(bus.dbg_gnt), 32'd0);
      check("post_rst_core_hold", 32'(bus.core_hold), 32'd0);
      tick();

      // Locked burst: 16 debug grants, one core, relock; without lock: strict alternation.
      for (int i = 1; i <= 18; i++) begin
         int exp_d;
         sample();
         exp_d = LockEn ? ((i == 17) ? 0 : 1) : (i % 2);
         check("burst_dbg_gnt", 32'(bus.dbg_gnt), 32'(exp_d));
         check("burst_core_hold", 32'(bus.core_hold), 32'(exp_d));
         tick();
      end

      // Long lock with no core traffic, then a core request must win at once.
      bus.core_req = 1'b0;
      for (int i = 0; i < 20; i++) begin
         sample();
         tick();
      end
      bus.core_req = 1'b1;
      sample();
      check("sat_dbg_gnt", 32'(bus.dbg_gnt), 32'd0);
      check("sat_core_hold", 32'(bus.core_hold), 32'd0);
      tick();

      // Lock dropped under contention: debug counts as last, so core wins.
      bus.core_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sample();
         tick();
      end
      bus.core_req = 1'b1; bus.dbg_lock = 1'b0;
      sample();
      check("unlock_dbg_gnt", 32'(bus.dbg_gnt), 32'd0);
      tick();
      sample();
      check("unlock_next_dbg_gnt", 32'(bus.dbg_gnt), 32'd1);
      tick();

      clear_inputs();
      sample();
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, byte-address width of the shared data RAM.
REQ-002 Parameter LOCK_MAX, default 16, maximum consecutive locked debug grants.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 core_req  input  1  MEM-stage access request.
REQ-006 core_we  input  4  byte write enables; 0 = read.
REQ-007 core_addr  input  32  core byte address; bits [ADDR_W-1:2] used.
REQ-008 core_wdata  input  32  core write data.
REQ-009 core_hold  output  1  pipeline stall to core.
REQ-010 core_rdata / core_rvld  output  32 / 1  core read data and valid pulse.
REQ-011 dbg_req, dbg_lock  input  1, 1  debug/loader request; burst-lock request.
REQ-012 dbg_we, dbg_addr, dbg_wdata  input  4, 32, 32  debug access fields.
REQ-013 dbg_gnt  output  1  debug access accepted this cycle.
REQ-014 dbg_rdata / dbg_rvld  output  32 / 1  debug read data and valid pulse.
REQ-015 mem_en, mem_we, mem_addr, mem_wdata  output  1, 4, ADDR_W-2, 32  RAM port.
REQ-016 mem_rdata  input  32  RAM read data, valid one cycle after mem_en with mem_we=0.

Function
REQ-017 One RAM access per cycle; winner selected combinationally from registered state and current requests.
REQ-018 States: IDLE, CORE, DBG, LOCK; state = last cycle's grant.
- IDLE/CORE/DBG: one requester -> it wins; both -> one not granted last cycle (IDLE counts as last=DBG).
- Debug win with dbg_lock=1 -> next state LOCK.
- LOCK: debug wins while dbg_req&dbg_lock; lock_cnt increments per locked grant.
- LOCK exit: dbg_lock=0 or dbg_req=0 -> normal rules with last=DBG.
- lock_cnt reaches LOCK_MAX-1 and core_req=1 -> next cycle core forced grant, lock_cnt cleared, state CORE.
- No requests -> IDLE.
REQ-019 mem_en = any grant; mem_we/mem_addr/mem_wdata = winner's fields, zero when idle.
REQ-020 core_hold = core_req & ~core_grant, combinational, same cycle.
REQ-021 dbg_gnt = debug grant, combinational.
REQ-022 Read owner registered at grant; next cycle owner's rvld=1 for exactly one cycle, rdata = mem_rdata; non-owner rdata = 0.
REQ-023 Writes produce no rvld.
REQ-024 Back-to-back reads by alternating requesters return data in grant order, no bubble.
REQ-025 lock_cnt width = clog2(LOCK_MAX); saturates, no wrap.

Reset
REQ-026 rst=0 asynchronously: state IDLE, last=DBG, lock_cnt=0, rvld both 0, in-flight read discarded.
REQ-027 During and after reset, before first clock edge: outputs follow REQ-019..021 with IDLE state; core has priority on the first contended cycle.

Configuration
REQ-028 Macro MEM_ARB_LOCK_EN.
- Defined: LOCK state, lock_cnt and REQ-018 lock rules present.
- Undefined: dbg_lock ignored, no LOCK state or lock_cnt, pure round-robin, LOCK_MAX unused.

Verification
REQ-029 Core read alone at addr 0x010, mem_rdata=0xDEADBEEF -> mem_addr=4, core_hold=0, next cycle core_rvld=1, core_rdata=0xDEADBEEF.
REQ-030 Both request continuously from reset, no lock -> grants C,D,C,D; core_hold=1 on D cycles only.
REQ-031 MEM_ARB_LOCK_EN: dbg_req=dbg_lock=1, core_req=1 throughout -> 16 debug grants, one core grant, debug relocks.
REQ-032 Debug write we=0xF addr 0x020 data 0x12345678 -> mem_we=0xF, mem_addr=8, no dbg_rvld.
REQ-033 rst=0 in cycle after core read grant -> core_rvld stays 0; after release, both requests -> core wins first.
REQ-034 MEM_ARB_LOCK_EN undefined, dbg_lock=1 with contention -> strict alternation.
